// File: rtl/ild1420_rx.sv
// ILD1420 serial receiver: UART byte framing followed by a 3-byte packet
// sequencer that rebuilds the 16-bit distance and 2-bit error code.
`timescale 1ns/1ps
module ild1420_rx #(
  parameter int CLKS_PER_BIT = 218,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [15:0] distance,
  output logic [1:0]  error,
  output logic        valid,
  output logic        frame_err,
  output logic        seq_err,
  output logic        busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} byte_st_t;
  typedef enum logic [1:0] {EXPECT_LO, EXPECT_MID, EXPECT_HI} phase_t;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   ds;
  byte_st_t               state;
  logic [TW-1:0]          timer;
  logic [3:0]             bit_cnt;
  logic                   bit_tick;
  logic [7:0]             shift_p1;
  logic                   byte_vld_p1;
  logic                   frame_bad_p1;
  phase_t                 phase;
  logic [1:0]             tag;
  logic [5:0]             payload;
  logic [5:0]             lo_p2;
  logic [5:0]             mid_p2;
  logic                   lo_we;
  logic                   mid_we;

  // ---- stage p0: metastability chain, idles high ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p0 <= '1;
    else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
  end

  assign ds = sync_p0[SYNC_STAGES-1];

  // ---- stage p1: byte framing FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      busy         <= 1'b0;
      byte_vld_p1  <= 1'b0;
      frame_bad_p1 <= 1'b0;
    end else begin
      byte_vld_p1  <= 1'b0;
      frame_bad_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!ds) begin
            state <= S_START;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (timer == T_HALF) begin
            if (ds) begin
              // line went back high before mid start bit: treat as noise
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= S_DATA;
              timer   <= '0;
              bit_cnt <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= S_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STOP: begin
          if (timer == T_FULL) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (ds) byte_vld_p1  <= 1'b1;
            else    frame_bad_p1 <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bit_tick = (state == S_DATA) && (timer == T_FULL);

  always_ff @(posedge clk) begin
    if (bit_tick) shift_p1 <= {ds, shift_p1[7:1]};
  end

  // ---- stage p2: packet sequencer ----
  assign tag     = shift_p1[7:6];
  assign payload = shift_p1[5:0];
  assign lo_we   = byte_vld_p1 && (tag == 2'b00);
  assign mid_we  = byte_vld_p1 && (tag == 2'b01) && (phase == EXPECT_MID);

  always_ff @(posedge clk) begin
    if (lo_we)  lo_p2  <= payload;
    if (mid_we) mid_p2 <= payload;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= EXPECT_LO;
      distance  <= '0;
      error     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      seq_err   <= 1'b0;
      if (frame_bad_p1) begin
        frame_err <= 1'b1;
        phase     <= EXPECT_LO;
      end else if (byte_vld_p1) begin
        if (tag == 2'b00) begin
          // a LO tag always restarts the packet, flagging any abandoned one
          phase   <= EXPECT_MID;
          seq_err <= (phase != EXPECT_LO);
        end else if ((tag == 2'b01) && (phase == EXPECT_MID)) begin
          phase <= EXPECT_HI;
        end else if ((tag == 2'b10) && (phase == EXPECT_HI)) begin
          distance <= {payload[3:0], mid_p2, lo_p2};
          error    <= payload[5:4];
          valid    <= 1'b1;
          phase    <= EXPECT_LO;
        end else begin
          seq_err <= 1'b1;
          phase   <= EXPECT_LO;
        end
      end
    end
  end

endmodule

// File: tb/tb_ild1420_rx.sv
// Directed bench for ild1420_rx: stimulus pushes hand-computed expected events,
// a monitor pops and compares them whenever the receiver pulses an output.
`timescale 1ns/1ps
module tb_ild1420_rx;

  localparam int CPB = 218;
  localparam int SS  = 2;
  // cycles from the start-bit drive edge to the edge that raises the pulse
  localparam int LAT = SS + 1 + CPB / 2 + 9 * CPB + 1;

  localparam int EV_NONE  = -1;
  localparam int EV_VALID = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_SEQ   = 2;

  typedef struct {
    int          kind;
    logic [15:0] d;
    logic [1:0]  e;
    longint      at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b1;
  logic [15:0] distance;
  logic [1:0]  error;
  logic        valid, frame_err, seq_err, busy;

  longint cyc = 0;
  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;

  ild1420_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .distance(distance), .error(error),
    .valid(valid), .frame_err(frame_err), .seq_err(seq_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Caller is always 1 ns after a rising edge, so frames start edge-aligned.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int kind,
                           input logic [15:0] d, input logic [1:0] e);
    logic [9:0] fr;
    exp_t       x;
    fr = {stop_ok, b, 1'b0};
    if (kind != EV_NONE) begin
      x.kind = kind; x.d = d; x.e = e; x.at = cyc + LAT;
      sb.push_back(x);
    end
    for (int i = 0; i < 9; i++) begin
      din = fr[i];
      idle(CPB);
    end
    if (stop_ok) begin
      din = 1'b1;
      idle(CPB);
    end else begin
      din = 1'b0;
      idle(CPB / 2 + 10);
      din = 1'b1;
      idle(CPB - CPB / 2 - 10);
    end
  endtask

  // Monitor: every pulse must match the next queued expectation.
  initial begin
    exp_t x;
    int   k;
    forever begin
      @(negedge clk);
      if (valid || frame_err || seq_err) begin
        k = valid ? EV_VALID : (frame_err ? EV_FRAME : EV_SEQ);
        checks++;
        if (int'(valid) + int'(frame_err) + int'(seq_err) != 1) begin
          errors++;
          $display("FAIL pulse_exclusive: valid=%0b frame_err=%0b seq_err=%0b at cycle %0d",
                   valid, frame_err, seq_err, cyc);
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", k, cyc);
        end else begin
          x = sb.pop_front();
          checks++;
          if (k != x.kind) begin
            errors++;
            $display("FAIL pulse_kind: got %0d expected %0d at cycle %0d", k, x.kind, cyc);
          end
          checks++;
          if (cyc != x.at) begin
            errors++;
            $display("FAIL pulse_latency: got cycle %0d expected cycle %0d", cyc, x.at);
          end
          if (x.kind == EV_VALID) begin
            checks++;
            if (distance !== x.d) begin
              errors++;
              $display("FAIL distance: got 0x%04h expected 0x%04h", distance, x.d);
            end
            checks++;
            if (error !== x.e) begin
              errors++;
              $display("FAIL error_code: got %02b expected %02b", error, x.e);
            end
          end
        end
      end
    end
  end

  initial begin
    #(800000);
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    din   = 1'b1;
    rst_n = 1'b0;
    idle(5);
    chk("rst_distance", 32'(distance), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_seq_err", 32'(seq_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(10);

    // nominal, back-to-back
    send_byte(8'h34, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h48, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h91, 1'b1, EV_VALID, 16'h1234, 2'b01);
    idle(50);

    // extremes
    send_byte(8'h3F, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h7F, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'hBF, 1'b1, EV_VALID, 16'hFFFF, 2'b11);
    idle(1000);
    send_byte(8'h00, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h40, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h80, 1'b1, EV_VALID, 16'h0000, 2'b00);
    idle(1000);

    // framing error, then recovery
    send_byte(8'h34, 1'b0, EV_FRAME, 16'h0, 2'b00);
    idle(1000);
    send_byte(8'h01, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h40, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h80, 1'b1, EV_VALID, 16'h0001, 2'b00);
    idle(100);

    // sequence errors and resync
    send_byte(8'h34, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h91, 1'b1, EV_SEQ, 16'h0, 2'b00);
    idle(100);
    send_byte(8'h05, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h05, 1'b1, EV_SEQ, 16'h0, 2'b00);
    send_byte(8'h40, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h80, 1'b1, EV_VALID, 16'h0005, 2'b00);
    idle(100);

    // glitch rejection
    din = 1'b0;
    idle(10);
    chk("glitch_busy_high", 32'(busy), 32'h1);
    idle(40);
    din = 1'b1;
    idle(CPB / 2 + SS + 4);
    chk("glitch_busy_low", 32'(busy), 32'h0);
    idle(200);

    // reset during the MID byte
    send_byte(8'h34, 1'b1, EV_NONE, 16'h0, 2'b00);
    din = 1'b0;
    idle(3 * CPB);
    chk("mid_byte_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    idle(2);
    chk("midrst_distance", 32'(distance), 32'h0);
    chk("midrst_error", 32'(error), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_pulses", {29'h0, valid, frame_err, seq_err}, 32'h0);
    din = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(20);
    chk("postrst_busy", 32'(busy), 32'h0);
    send_byte(8'h34, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h48, 1'b1, EV_NONE, 16'h0, 2'b00);
    send_byte(8'h91, 1'b1, EV_VALID, 16'h1234, 2'b01);
    idle(100);

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
